// File: rtl/spi_controller.sv
// spi_controller
//   SPI bus initiator for the opcode / operand / response protocol of the FPGA
//   SPI peripheral. A transaction is one opcode byte, then write_count_in
//   operand bytes (fetched over a tx valid/ready port), then read_count_in
//   response bytes (delivered as rx_valid_out pulses). SPI mode 0, MSB first.
//
// Ports
//   clock_in, reset_in          system clock, synchronous active-high reset
//   start_in, opcode_in,
//   write_count_in,
//   read_count_in               transaction request, latched when accepted
//   tx_data_in, tx_valid_in,
//   tx_ready_out                operand byte stream into the controller
//   rx_data_out, rx_valid_out   response byte stream out of the controller
//   busy_out, done_out          transaction status
//   spi_select_out,
//   spi_clock_out,
//   spi_data_out, spi_data_in   SPI pins (CS_n, SCK, MOSI, MISO)
//   fsm_state                   current FSM state, for debug and checkers
//
// Handshake: an operand byte moves on every rising clock edge where
// tx_valid_in and tx_ready_out are both high. tx_ready_out never depends
// combinationally on tx_valid_in; once tx_valid_in is raised the source holds
// it and tx_data_in stable until the transfer edge.

module spi_controller #(
  parameter int CLOCK_DIVIDER = 2
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       start_in,
  input  logic [7:0] opcode_in,
  input  logic [7:0] write_count_in,
  input  logic [7:0] read_count_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       spi_select_out,
  output logic       spi_clock_out,
  output logic       spi_data_out,
  input  logic       spi_data_in,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] HIGH     = 3'd2;
  localparam logic [2:0] LOW      = 3'd3;
  localparam logic [2:0] NEXT     = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;
  localparam logic [2:0] DESELECT = 3'd6;

  localparam int DW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDER - 1);
  // done_out must be visible in the last DESELECT cycle, so it is registered
  // one cycle earlier (only meaningful when CLOCK_DIVIDER > 1).
  localparam logic [DW-1:0] DIV_PRE  = DW'((CLOCK_DIVIDER > 1) ? CLOCK_DIVIDER - 2 : 0);

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    wr_left;
  logic [7:0]    rd_left;
  logic          in_read;    // byte currently on the wire is a response byte
  logic [6:0]    tx_shift;   // bits still to send after the one on MOSI
  logic [7:0]    rx_shift;
  logic          div_last;

  assign div_last  = (div_cnt == DIV_LAST);
  assign busy_out  = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= 3'd7;
      wr_left        <= 8'd0;
      rd_left        <= 8'd0;
      in_read        <= 1'b0;
      tx_shift       <= 7'd0;
      rx_shift       <= 8'd0;
      rx_data_out    <= 8'd0;
      rx_valid_out   <= 1'b0;
      tx_ready_out   <= 1'b0;
      done_out       <= 1'b0;
      spi_select_out <= 1'b1;
      spi_clock_out  <= 1'b0;
      spi_data_out   <= 1'b0;
    end else begin
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            wr_left        <= write_count_in;
            rd_left        <= read_count_in;
            tx_shift       <= opcode_in[6:0];
            spi_data_out   <= opcode_in[7];
            spi_select_out <= 1'b0;
            spi_clock_out  <= 1'b0;
            bit_cnt        <= 3'd7;
            div_cnt        <= '0;
            in_read        <= 1'b0;
            state          <= SETUP;
          end
        end

        SETUP: begin
          if (div_last) begin
            div_cnt       <= '0;
            spi_clock_out <= 1'b1;
            state         <= HIGH;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        HIGH: begin
          if (div_last) begin
            div_cnt       <= '0;
            spi_clock_out <= 1'b0;
            rx_shift      <= {rx_shift[6:0], spi_data_in};
            spi_data_out  <= tx_shift[6];
            tx_shift      <= {tx_shift[5:0], 1'b0};
            state         <= LOW;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt != 3'd0) begin
              bit_cnt       <= bit_cnt - 3'd1;
              spi_clock_out <= 1'b1;
              state         <= HIGH;
            end else begin
              // Byte boundary: decide what follows without spending an
              // extra cycle, so a transaction with nothing left goes
              // straight to HOLD.
              bit_cnt <= 3'd7;
              if (in_read) begin
                rx_valid_out <= 1'b1;
                rx_data_out  <= rx_shift;
              end
              if (wr_left != 8'd0) begin
                tx_ready_out <= 1'b1;
                state        <= NEXT;
              end else if (rd_left != 8'd0) begin
                rd_left      <= rd_left - 8'd1;
                in_read      <= 1'b1;
                tx_shift     <= 7'd0;
                spi_data_out <= 1'b0;
                state        <= NEXT;
              end else begin
                state <= HOLD;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        NEXT: begin
          // While an operand is outstanding the divider is frozen, so a
          // stall keeps SCK low and select asserted. The handshake cycle
          // itself is the first of the CLOCK_DIVIDER low cycles.
          if (!(tx_ready_out && !tx_valid_in)) begin
            if (tx_ready_out) begin
              tx_ready_out <= 1'b0;
              wr_left      <= wr_left - 8'd1;
              tx_shift     <= tx_data_in[6:0];
              spi_data_out <= tx_data_in[7];
            end
            if (div_last) begin
              div_cnt       <= '0;
              spi_clock_out <= 1'b1;
              state         <= HIGH;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
        end

        HOLD: begin
          if (div_last) begin
            div_cnt        <= '0;
            spi_select_out <= 1'b1;
            spi_data_out   <= 1'b0;
            state          <= DESELECT;
            if (CLOCK_DIVIDER == 1) begin
              done_out <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        DESELECT: begin
          if (div_last) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
            if (div_cnt == DIV_PRE) begin
              done_out <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Randomized and directed bench for spi_controller. A behavioural SPI
//   target model watches the pins, collects MOSI bytes and serves MISO from a
//   prepared byte stream; expected byte sequences, edge counts and select
//   timing come from the protocol rules (bytes on the wire, cycles per bit).

module tb_spi_controller;

  localparam int CD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_in = 1'b1;
  logic       start_in = 1'b0;
  logic [7:0] opcode_in = 8'd0;
  logic [7:0] write_count_in = 8'd0;
  logic [7:0] read_count_in = 8'd0;
  logic [7:0] tx_data_in = 8'd0;
  logic       tx_valid_in = 1'b0;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       busy_out;
  logic       done_out;
  logic       spi_select_out;
  logic       spi_clock_out;
  logic       spi_data_out;
  logic       spi_data_in = 1'b0;
  logic [2:0] fsm_state;

  spi_controller #(.CLOCK_DIVIDER(CD)) dut (
    .clock_in(clk), .reset_in(reset_in), .start_in(start_in),
    .opcode_in(opcode_in), .write_count_in(write_count_in),
    .read_count_in(read_count_in), .tx_data_in(tx_data_in),
    .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
    .busy_out(busy_out), .done_out(done_out),
    .spi_select_out(spi_select_out), .spi_clock_out(spi_clock_out),
    .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
    .fsm_state(fsm_state)
  );

  // Second instance with the fastest divider.
  logic       start1 = 1'b0;
  logic [7:0] op1 = 8'd0;
  logic       tx_ready1, rx_valid1, busy1, done1, sel1, sck1, mosi1;
  logic [7:0] rx_data1;
  logic [2:0] fsm_state1;

  spi_controller #(.CLOCK_DIVIDER(1)) dut1 (
    .clock_in(clk), .reset_in(reset_in), .start_in(start1),
    .opcode_in(op1), .write_count_in(8'd0), .read_count_in(8'd0),
    .tx_data_in(8'd0), .tx_valid_in(1'b0), .tx_ready_out(tx_ready1),
    .rx_data_out(rx_data1), .rx_valid_out(rx_valid1),
    .busy_out(busy1), .done_out(done1),
    .spi_select_out(sel1), .spi_clock_out(sck1),
    .spi_data_out(mosi1), .spi_data_in(1'b0),
    .fsm_state(fsm_state1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- SPI target model / monitor ----------------
  logic [7:0] miso_stream[$];   // bytes the target returns, one per byte slot
  logic [7:0] mosi_q[$];        // bytes seen on MOSI
  logic [7:0] rx_q[$];          // bytes reported on rx_valid_out
  int gen = 0, seen_gen = 0;
  int rise_cnt, bit_n, sel_low_cyc, desel_run, desel_at_done, done_cnt, glitch;
  int high_run, low_run;
  logic [7:0] mosi_acc;
  logic sck_prev;

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen    = gen;
      mosi_q      = {};
      rx_q        = {};
      rise_cnt    = 0;
      bit_n       = 0;
      sel_low_cyc = 0;
      done_cnt    = 0;
      glitch      = 0;
      desel_at_done = -1;
    end
    if (!spi_select_out) begin
      sel_low_cyc++;
      desel_run = 0;
    end else begin
      desel_run++;
    end
    if (spi_clock_out && spi_select_out) glitch++;
    if (spi_clock_out) begin
      if (!sck_prev) begin
        if (low_run < CD) glitch++;
        rise_cnt++;
        mosi_acc = {mosi_acc[6:0], spi_data_out};
        bit_n++;
        if (bit_n == 8) begin
          mosi_q.push_back(mosi_acc);
          bit_n = 0;
        end
      end
      high_run++;
      low_run = 0;
    end else begin
      if (sck_prev && high_run != CD) glitch++;
      low_run++;
      high_run = 0;
      // Mode 0 target: next MISO bit is presented while SCK is low.
      if (rise_cnt / 8 < miso_stream.size())
        spi_data_in = miso_stream[rise_cnt / 8][7 - (rise_cnt % 8)];
      else
        spi_data_in = 1'b0;
    end
    sck_prev = spi_clock_out;
    if (rx_valid_out) rx_q.push_back(rx_data_out);
    if (done_out) begin
      done_cnt++;
      desel_at_done = desel_run;
    end
  end

  // ---------------- driver + scoreboard per transaction ----------------
  logic [7:0] wq[$];   // operand bytes to supply
  logic [7:0] rq[$];   // response bytes the target returns

  task automatic run_txn(input logic [7:0] op, input int w, input int r,
                         input int stall_idx, input int stall_len, input int poke_cyc);
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_q[$];
    int cyc, wr_idx, stall_wait, hs_cnt, stall_bad, extra;
    bit hs_pending;

    miso_stream = {};
    for (int i = 0; i < 1 + w; i++) miso_stream.push_back(8'($urandom));
    for (int i = 0; i < r; i++) miso_stream.push_back(rq[i]);
    exp_q = {};
    exp_q.push_back(op);
    for (int i = 0; i < w; i++) exp_q.push_back(wq[i]);
    for (int i = 0; i < r; i++) exp_q.push_back(8'h00);
    exp_rx_q = {};
    for (int i = 0; i < r; i++) exp_rx_q.push_back(rq[i]);
    extra = (stall_idx >= 0 && stall_idx < w) ? stall_len : 0;

    gen++;
    step();
    cyc = 0;
    while (busy_out && cyc < 1000) begin
      step();
      cyc++;
    end
    opcode_in      = op;
    write_count_in = 8'(w);
    read_count_in  = 8'(r);
    start_in       = 1'b1;
    step();
    start_in  = 1'b0;
    opcode_in = 8'($urandom);
    check_eq("accept_busy", busy_out, 1);
    check_eq("accept_select", spi_select_out, 0);

    wr_idx = 0; stall_wait = 0; hs_cnt = 0; hs_pending = 0; stall_bad = 0; cyc = 0;
    while (done_out !== 1'b1 && cyc < 20000) begin
      if (hs_pending) begin
        wr_idx++;
        hs_cnt++;
      end
      start_in = (cyc == poke_cyc);
      if (wr_idx < w) begin
        if (wr_idx == stall_idx && stall_wait < stall_len) begin
          tx_valid_in = 1'b0;
          if (tx_ready_out) begin
            stall_wait++;
            if (spi_clock_out || spi_select_out) stall_bad++;
          end
        end else begin
          tx_valid_in = 1'b1;
          tx_data_in  = wq[wr_idx];
        end
      end else begin
        tx_valid_in = 1'b0;
      end
      hs_pending = tx_valid_in && tx_ready_out;
      step();
      cyc++;
    end
    start_in    = 1'b0;
    tx_valid_in = 1'b0;

    check_eq("done_seen", done_out, 1);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("rx_before_done", rx_q.size(), r);
    check_eq("mosi_len", mosi_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mosi_q.size(); i++)
      check_eq($sformatf("mosi_byte%0d", i), mosi_q[i], exp_q[i]);
    for (int i = 0; i < exp_rx_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("rx_byte%0d", i), rx_q[i], exp_rx_q[i]);
    check_eq("sck_rises", rise_cnt, 8 * (1 + w + r));
    check_eq("tx_handshakes", hs_cnt, w);
    check_eq("select_low_cycles", sel_low_cyc,
             CD * (2 + 16 * (1 + w + r)) + (w + r) * CD + extra);
    check_eq("sck_glitch", glitch, 0);
    check_eq("deselect_at_done", desel_at_done, CD);
    check_eq("stall_pins", stall_bad, 0);
  endtask

  // ---------------- main sequence ----------------
  int sel1_low, rises1, done1_cyc, period_bad, last_rise, ones1;
  logic prev1;

  initial begin
    sck_prev = 1'b0; high_run = 0; low_run = 0; desel_run = 0; mosi_acc = 8'd0;
    repeat (3) step();
    check_eq("rst_select", spi_select_out, 1);
    check_eq("rst_sck", spi_clock_out, 0);
    check_eq("rst_mosi", spi_data_out, 0);
    check_eq("rst_tx_ready", tx_ready_out, 0);
    check_eq("rst_rx_valid", rx_valid_out, 0);
    check_eq("rst_rx_data", rx_data_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_done", done_out, 0);
    reset_in = 1'b0;
    step();

    // Opcode plus one response byte.
    wq = {}; rq = {8'h81};
    run_txn(8'hDB, 0, 1, -1, 0, -1);

    // Two operands, valid held high.
    wq = {8'hA5, 8'h3C}; rq = {};
    run_txn(8'h20, 2, 0, -1, 0, -1);

    // Operand source stalls 50 cycles before the second operand.
    wq = {8'h11, 8'hC3, 8'h7E}; rq = {8'h5A};
    run_txn(8'h42, 3, 1, 1, 50, -1);

    // start_in pulsed while busy is ignored; the chained call starts in the
    // cycle after done_out.
    wq = {8'h99}; rq = {8'hE7};
    run_txn(8'h0F, 1, 1, -1, 0, 10);
    wq = {}; rq = {};
    run_txn(8'hF0, 0, 0, -1, 0, -1);

    // Reset in the middle of the opcode.
    gen++;
    step();
    opcode_in = 8'h5A; write_count_in = 8'd1; read_count_in = 8'd1; start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (5) step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check_eq("midrst_select", spi_select_out, 1);
    check_eq("midrst_sck", spi_clock_out, 0);
    check_eq("midrst_busy", busy_out, 0);
    check_eq("midrst_tx_ready", tx_ready_out, 0);
    repeat (6) step();
    check_eq("midrst_no_done", done_cnt, 0);
    wq = {8'h3D}; rq = {8'hB4, 8'h02};
    run_txn(8'hA1, 1, 2, -1, 0, -1);

    // Randomized transactions, back to back.
    for (int t = 0; t < 8; t++) begin
      int w, r;
      w = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      wq = {}; rq = {};
      for (int i = 0; i < w; i++) wq.push_back(8'($urandom));
      for (int i = 0; i < r; i++) rq.push_back(8'($urandom));
      if (t == 3 && w > 0)
        run_txn(8'($urandom), w, r, 0, $urandom_range(1, 20), -1);
      else
        run_txn(8'($urandom), w, r, -1, 0, -1);
    end

    // Divider of one: opcode-only 0xFF.
    step();
    op1 = 8'hFF; start1 = 1'b1;
    step();
    start1 = 1'b0;
    sel1_low = 0; rises1 = 0; done1_cyc = 0; period_bad = 0; last_rise = -1; ones1 = 0; prev1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!sel1) sel1_low++;
      if (sck1 && !prev1) begin
        rises1++;
        if (mosi1) ones1++;
        if (last_rise >= 0 && c - last_rise != 2) period_bad++;
        last_rise = c;
      end
      prev1 = sck1;
      if (done1 && done1_cyc == 0) done1_cyc = c;
      step();
    end
    check_eq("cd1_select_low", sel1_low, 18);
    check_eq("cd1_done_cycle", done1_cyc, 19);
    check_eq("cd1_sck_rises", rises1, 8);
    check_eq("cd1_sck_period", period_bad, 0);
    check_eq("cd1_mosi_ones", ones1, 8);
    check_eq("cd1_idle_after", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
